// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and constants for the RV32I load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Controller states: idle, bus request outstanding, one-cycle writeback
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } lsu_state_e;

    // RV32I funct3 width/sign codes shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane enable pattern for an access of the given width code at a
    // byte offset; byte and halfword masks slide with the offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size_code,
                                             input logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size_code)
            2'b00:   mask = 4'b0001 << offset;
            2'b01:   mask = offset[1] ? 4'b1100 : 4'b0011;
            2'b10:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane steering for the load/store unit: legality
//            and alignment checks, store byte enables / replicated write data
//            and load extraction with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    output logic [31:0] load_data_o,
    output logic        legal_o,
    output logic        misaligned_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Decode legality, alignment, lane enables and replicated store data
    always_comb begin
        legal_o      = 1'b0;
        misaligned_o = 1'b0;
        bus_sel_o    = 4'b0000;
        bus_wdata_o  = 32'h0000_0000;
        case (funct3_i)
            F3_B: begin
                legal_o     = 1'b1;
                bus_sel_o   = lane_mask(2'b00, addr_i);
                bus_wdata_o = {4{store_data_i[7:0]}};
            end
            F3_H: begin
                legal_o      = 1'b1;
                misaligned_o = addr_i[0];
                bus_sel_o    = lane_mask(2'b01, addr_i);
                bus_wdata_o  = {2{store_data_i[15:0]}};
            end
            F3_W: begin
                legal_o      = 1'b1;
                misaligned_o = (addr_i != 2'b00);
                bus_sel_o    = lane_mask(2'b10, addr_i);
                bus_wdata_o  = store_data_i;
            end
            // Unsigned variants only exist for loads
            F3_BU: begin
                legal_o   = ~is_store_i;
                bus_sel_o = lane_mask(2'b00, addr_i);
            end
            F3_HU: begin
                legal_o      = ~is_store_i;
                misaligned_o = addr_i[0];
                bus_sel_o    = lane_mask(2'b01, addr_i);
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the returned bus word
    always_comb begin
        w_half = addr_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (addr_i)
            2'b00:   w_byte = bus_rdata_i[7:0];
            2'b01:   w_byte = bus_rdata_i[15:8];
            2'b10:   w_byte = bus_rdata_i[23:16];
            default: w_byte = bus_rdata_i[31:24];
        endcase
    end

    // Extend the extracted field to a full register value
    always_comb begin
        case (funct3_i)
            F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
            F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
            F3_W:    load_data_o = bus_rdata_i;
            F3_BU:   load_data_o = {24'h00_0000, w_byte};
            F3_HU:   load_data_o = {16'h0000, w_half};
            default: load_data_o = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Multi-cycle RV32I load/store engine. Accepts one request from
//            execute, issues a single word-aligned bus transaction, then
//            completes with a one-cycle writeback/done pulse. Illegal or
//            misaligned requests and bus timeouts complete with err.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] reg_write,
    output logic [4:0]  rd,
    output logic        write,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Last counter value before the request is abandoned
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

    lsu_state_e    state_q;
    logic [TW-1:0] cnt_q;

    // Request fields captured when the request is accepted
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [1:0]    addr_lo_q;
    logic [4:0]    rd_lat_q;

    // Registered outputs
    logic          bus_read_q;
    logic          bus_write_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_sel_q;
    logic [31:0]   reg_write_q;
    logic [4:0]    rd_q;
    logic          write_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    // Alignment unit sees the live request while idle (to decide acceptance
    // and lane enables) and the captured request afterwards (for load data)
    logic          w_is_store;
    logic [2:0]    w_funct3;
    logic [1:0]    w_addr_lo;
    logic [3:0]    w_sel;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load_data;
    logic          w_legal;
    logic          w_misaligned;

    assign w_is_store = (state_q == IDLE) ? is_store   : is_store_q;
    assign w_funct3   = (state_q == IDLE) ? funct3     : funct3_q;
    assign w_addr_lo  = (state_q == IDLE) ? addr[1:0]  : addr_lo_q;

    lsu_align u_align (
        .is_store_i   (w_is_store),
        .funct3_i     (w_funct3),
        .addr_i       (w_addr_lo),
        .store_data_i (store_data),
        .bus_rdata_i  (bus_rdata),
        .bus_sel_o    (w_sel),
        .bus_wdata_o  (w_wdata),
        .load_data_o  (w_load_data),
        .legal_o      (w_legal),
        .misaligned_o (w_misaligned)
    );

    // Controller: request capture, bus handshake with timeout, writeback pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_lat_q    <= 5'd0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            bus_sel_q   <= 4'b0000;
            reg_write_q <= 32'h0000_0000;
            rd_q        <= 5'd0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Completion strobes are single-cycle by default
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        addr_lo_q  <= addr[1:0];
                        rd_lat_q   <= rd_in;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        if (w_legal && !w_misaligned) begin
                            state_q     <= REQ;
                            bus_read_q  <= ~is_store;
                            bus_write_q <= is_store;
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_sel_q   <= w_sel;
                            bus_wdata_q <= is_store ? w_wdata : 32'h0000_0000;
                        end else begin
                            // Rejected without touching the bus
                            state_q <= WB;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state_q     <= WB;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        cnt_q       <= '0;
                        if (!is_store_q) begin
                            reg_write_q <= w_load_data;
                            rd_q        <= rd_lat_q;
                            write_q     <= (rd_lat_q != 5'd0);
                        end
                    end else if (cnt_q == c_TMO_LAST) begin
                        state_q     <= WB;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                WB: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    bus_read_q  <= 1'b0;
                    bus_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign reg_write = reg_write_q;
    assign rd        = rd_q;
    assign write     = write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire
